// File: rtl/gpio_debounce_pkg.sv
// Shared types and helpers for the GPIO debounce block.
// State encodings, released-level and tick-divider helpers.
package gpio_debounce_pkg;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

    localparam logic [9:0] MS_LAST = 10'd999;

    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    // clk_freq/1e6 clamped to the 1..256 range the prescaler supports
    function automatic int unsigned us_divider(input logic [31:0] clk_freq);
        int unsigned div;
        div = clk_freq / 32'd1000000;
        if (div < 1) div = 1;
        if (div > 256) div = 256;
        return div;
    endfunction

endpackage

// File: rtl/gpio_debounce_channel.sv
// One GPIO channel: 2-FF synchroniser, time-based debounce FSM,
// press/release pulses and long-press detection.
module debounce_channel
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned debounce_us = 10000,
    parameter int unsigned hold_ms     = 1000,
    parameter bit          active_low  = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic pin,
    input  logic us_tick,
    input  logic ms_tick,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic held,
    output logic held_pulse
);

    localparam logic REL = released_level(active_low);
    localparam logic PRS = ~REL;
    localparam logic [15:0] DB_LAST   = 16'(debounce_us - 1);
    localparam logic [15:0] HOLD_LAST = 16'(hold_ms - 1);

    logic [1:0]  sync;
    logic        q_prev;
    db_state_t   state;
    logic [15:0] db_cnt;
    logic [15:0] hold_cnt;
    logic        s;
    logic        differ;
    logic        adv;
    logic        done;

    assign s      = sync[1];
    assign differ = (s != debounced);
    assign adv    = differ && us_tick;
    assign done   = adv && (db_cnt == DB_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync          <= {2{REL}};
            debounced     <= REL;
            q_prev        <= REL;
            state         <= DB_STABLE;
            db_cnt        <= 16'd0;
            hold_cnt      <= 16'd0;
            held          <= 1'b0;
            held_pulse    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[0], pin};
            q_prev        <= debounced;
            press_pulse   <= (debounced == PRS) && (q_prev == REL);
            release_pulse <= (debounced == REL) && (q_prev == PRS);
            held_pulse    <= 1'b0;

            unique case (state)
                DB_STABLE: begin
                    if (done) begin
                        debounced <= s;
                    end else if (differ) begin
                        state <= DB_PENDING;
                        if (adv) db_cnt <= db_cnt + 16'd1;
                    end
                end
                DB_PENDING: begin
                    // a bounce back to the settled level wins over a tick
                    if (!differ) begin
                        state  <= DB_STABLE;
                        db_cnt <= 16'd0;
                    end else if (done) begin
                        debounced <= s;
                        db_cnt    <= 16'd0;
                        state     <= DB_STABLE;
                    end else if (adv) begin
                        db_cnt <= db_cnt + 16'd1;
                    end
                end
                default: state <= DB_STABLE;
            endcase

            if (debounced == REL) begin
                hold_cnt <= 16'd0;
                held     <= 1'b0;
            end else if (ms_tick && !held) begin
                if (hold_cnt == HOLD_LAST) begin
                    held       <= 1'b1;
                    held_pulse <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input conditioner: shared us/ms tick generator feeding
// one debounce channel per pad.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned ninputs     = 16,
    parameter logic [31:0] clk_freq    = 32'd0,
    parameter int unsigned debounce_us = 10000,
    parameter int unsigned hold_ms     = 1000,
    parameter bit          active_low  = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [ninputs-1:0] pins,
    output logic [ninputs-1:0] debounced,
    output logic [ninputs-1:0] press_pulse,
    output logic [ninputs-1:0] release_pulse,
    output logic [ninputs-1:0] held,
    output logic [ninputs-1:0] held_pulse
);

    localparam int unsigned DIV      = us_divider(clk_freq);
    localparam logic [7:0]  PRE_LAST = 8'(DIV - 1);

    logic [7:0] pre;
    logic [9:0] ms_cnt;
    logic       us_tick;
    logic       ms_tick;

    assign us_tick = (pre == PRE_LAST);
    assign ms_tick = us_tick && (ms_cnt == MS_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pre    <= 8'd0;
            ms_cnt <= 10'd0;
        end else begin
            pre <= us_tick ? 8'd0 : pre + 8'd1;
            if (us_tick) begin
                ms_cnt <= (ms_cnt == MS_LAST) ? 10'd0 : ms_cnt + 10'd1;
            end
        end
    end

    for (genvar i = 0; i < ninputs; i++) begin : g_ch
        debounce_channel #(
            .debounce_us (debounce_us),
            .hold_ms     (hold_ms),
            .active_low  (active_low)
        ) u_ch (
            .sys_clk       (sys_clk),
            .sys_rst_n     (sys_rst_n),
            .pin           (pins[i]),
            .us_tick       (us_tick),
            .ms_tick       (ms_tick),
            .debounced     (debounced[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .held          (held[i]),
            .held_pulse    (held_pulse[i])
        );
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: 4 MHz clock, 10 us debounce,
// 2 ms hold, active-low pins, four channels.
module tb_gpio_debounce;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] pins = 4'h0;
    logic [3:0] debounced;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] held;
    logic [3:0] held_pulse;

    int checks = 0;
    int errors = 0;

    int press_cnt[4]   = '{default: 0};
    int release_cnt[4] = '{default: 0};
    int hpulse_cnt[4]  = '{default: 0};
    int db1_changes = 0;
    int width_err = 0;
    logic [3:0] pp_prev = 4'h0;
    logic [3:0] rp_prev = 4'h0;
    logic [3:0] hp_prev = 4'h0;
    logic       db1_prev = 1'b1;

    gpio_debounce #(
        .ninputs     (4),
        .clk_freq    (32'd4000000),
        .debounce_us (10),
        .hold_ms     (2),
        .active_low  (1'b1)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .pins          (pins),
        .debounced     (debounced),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .held          (held),
        .held_pulse    (held_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // event monitor, sampled away from the active edge
    always @(negedge sys_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i] === 1'b1) press_cnt[i]++;
            if (release_pulse[i] === 1'b1) release_cnt[i]++;
            if (held_pulse[i] === 1'b1) hpulse_cnt[i]++;
        end
        if (((press_pulse & pp_prev) | (release_pulse & rp_prev)
             | (held_pulse & hp_prev)) != 4'h0)
            width_err++;
        if (debounced[1] !== db1_prev) db1_changes++;
        pp_prev  = press_pulse;
        rp_prev  = release_pulse;
        hp_prev  = held_pulse;
        db1_prev = debounced[1];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs,
                               input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d",
                   tag, obs, lo, hi);
        end
    endtask

    initial begin
        int n;
        int base;
        int rel0;
        int rel3;
        logic hprev;

        // reset with all pins low (pressed level)
        sys_rst_n = 1'b0;
        pins = 4'h0;
        repeat (5) @(negedge sys_clk);
        check("rst_db", 32'(debounced), 32'hF);
        check("rst_held", 32'(held), 32'h0);
        check("rst_pulses", 32'({press_pulse, release_pulse, held_pulse}), 32'h0);

        pins = 4'hF;
        sys_rst_n = 1'b1;
        repeat (100) @(negedge sys_clk);
        check("idle_db", 32'(debounced), 32'hF);
        check("idle_pulses",
              32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                  + release_cnt[0] + release_cnt[1] + release_cnt[2]
                  + release_cnt[3] + hpulse_cnt[0] + hpulse_cnt[1]
                  + hpulse_cnt[2] + hpulse_cnt[3]), 32'h0);

        // clean press on channel 0
        pins[0] = 1'b0;
        n = 0;
        while (debounced[0] !== 1'b0 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check_range("press0_latency", n, 38, 46);
        check("press0_pulse_pre", 32'(press_pulse[0]), 32'h0);
        @(negedge sys_clk);
        check("press0_pulse_on", 32'(press_pulse[0]), 32'h1);
        @(negedge sys_clk);
        check("press0_pulse_off", 32'(press_pulse[0]), 32'h0);

        pins[0] = 1'b1;
        repeat (60) @(negedge sys_clk);
        check("rel0_db", 32'(debounced[0]), 32'h1);
        check("rel0_cnt", 32'(release_cnt[0]), 32'h1);
        check("press0_cnt", 32'(press_cnt[0]), 32'h1);

        // bounce on channel 1: 20-cycle toggles never reach 40 cycles
        base = db1_changes;
        for (int k = 0; k < 20; k++) begin
            pins[1] = (k % 2 == 1);
            repeat (20) @(negedge sys_clk);
        end
        pins[1] = 1'b1;
        repeat (60) @(negedge sys_clk);
        check("bounce_db_changes", 32'(db1_changes - base), 32'h0);
        check("bounce_press", 32'(press_cnt[1]), 32'h0);
        check("bounce_release", 32'(release_cnt[1]), 32'h0);
        check("bounce_db", 32'(debounced[1]), 32'h1);

        // long press on channel 2
        pins[2] = 1'b0;
        n = 0;
        while (debounced[2] !== 1'b0 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check_range("press2_latency", n, 38, 46);
        n = 0;
        while (held[2] !== 1'b1 && n < 12001) begin
            @(negedge sys_clk);
            n++;
        end
        check_range("held2_latency", n, 4000, 12000);
        check("held2_pulse_on", 32'(held_pulse[2]), 32'h1);
        repeat (2000) @(negedge sys_clk);
        check("held2_level", 32'(held[2]), 32'h1);
        check("held2_pulse_count", 32'(hpulse_cnt[2]), 32'h1);

        pins[2] = 1'b1;
        n = 0;
        hprev = held[2];
        while (release_pulse[2] !== 1'b1 && n < 200) begin
            hprev = held[2];
            @(negedge sys_clk);
            n++;
        end
        check("rel2_pulse_seen", 32'(release_pulse[2]), 32'h1);
        check("held2_before_rel", 32'(hprev), 32'h1);
        check("held2_at_rel", 32'(held[2]), 32'h0);

        // simultaneous press on channels 0 and 3
        pins = 4'b0110;
        n = 0;
        while (press_pulse === 4'h0 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("simul_press", 32'(press_pulse), 32'h9);
        check("simul_db", 32'(debounced), 32'h6);
        check("simul_ch1_press", 32'(press_cnt[1]), 32'h0);
        check("simul_ch2_press", 32'(press_cnt[2]), 32'h1);

        // reset during held (ch0/3) and pending debounce (ch1)
        n = 0;
        while (held[0] !== 1'b1 && n < 12001) begin
            @(negedge sys_clk);
            n++;
        end
        check("mid_held", 32'(held), 32'h9);
        pins[1] = 1'b0;
        repeat (20) @(negedge sys_clk);
        rel0 = release_cnt[0];
        rel3 = release_cnt[3];
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("mid_rst_db", 32'(debounced), 32'hF);
        check("mid_rst_held", 32'(held), 32'h0);
        sys_rst_n = 1'b1;
        n = 0;
        while (debounced !== 4'b0100 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check_range("rst_redebounce", n, 38, 46);
        repeat (3) @(negedge sys_clk);
        check("rst_no_release0", 32'(release_cnt[0]), 32'(rel0));
        check("rst_no_release3", 32'(release_cnt[3]), 32'(rel3));
        check("rst_press1_cnt", 32'(press_cnt[1]), 32'h1);
        check("pulse_width", 32'(width_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
